disp_update_ctrl: RTL and testbench
===================================

DISP_UPDATE_CTRL -- requirements
Module: disp_update_ctrl

Interface
REQ-001 SHALL have parameter: BLINK_FRAMES, 30, vblank rising edges per blink half-period (legal range 2..255).
REQ-002 SHALL have port: clk  in  1  system clock (100 MHz, same domain as the sync generator).
REQ-003 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port: vblank  in  1  level, high while the line counter is at or beyond 480; synchronous to clk.
REQ-005 SHALL have port: upd_valid  in  1  calculator offers a result.
REQ-006 SHALL have port: upd_ready  out  1  controller accepts a result.
REQ-007 SHALL have ports: upd_num3, upd_num2, upd_num1, upd_num0  in  4 each  BCD digits, most significant first.
REQ-008 SHALL have ports: upd_op  in  4  operator code; upd_neg  in  1  sign; upd_nan  in  1  not-a-number flag.
REQ-009 SHALL have ports: num3, num2, num1, num0  out  4 each; op  out  4; posneg  out  1; is_nan  out  1  (all registered display values).
REQ-010 SHALL have ports: digits_vis  out  1  digit glyphs enabled; commit  out  1  one-cycle pulse on display update; upd_err  out  1  sticky rejected-update flag.

Function
REQ-011 SHALL implement states IDLE, HOLD and COMMIT.
REQ-012 SHALL define a transfer as upd_valid=1 and upd_ready=1 at a rising clk edge.
REQ-013 SHALL drive upd_ready from a register whose value is 1 exactly when the state is IDLE.
REQ-014 SHALL treat an update as legal when all four digits are <=9 and upd_op is one of 0,1,2,3,5.
REQ-015 SHALL, on a legal transfer, capture all upd_* fields into a holding buffer, clear upd_err, move to HOLD and deassert upd_ready.
REQ-016 SHALL, on an illegal transfer, discard the data, set upd_err, remain in IDLE and keep upd_ready=1.
REQ-017 SHALL, in HOLD with vblank=1 at a clk edge, load all display outputs from the buffer, set commit=1 and move to COMMIT.
REQ-018 SHALL, in HOLD with vblank=0, hold the buffer and wait indefinitely.
REQ-019 SHALL, in COMMIT, clear commit, move to IDLE and set upd_ready=1 on the next edge, so commit is exactly one cycle wide.
REQ-020 SHALL never change the display outputs while vblank=0.
REQ-021 SHALL give a latency of 2 edges from a transfer made while vblank=1 to updated outputs, and 3 edges from that transfer to upd_ready=1.
REQ-022 SHALL detect vblank rising edges with a registered copy of vblank (reset value 0).
REQ-023 SHALL count vblank rising edges in a frame counter of ceil(log2(BLINK_FRAMES)) bits.
REQ-024 SHALL, at a rising edge with the counter at BLINK_FRAMES-1, wrap the counter to 0 and toggle blink_phase.
REQ-025 SHALL, on a commit that changes is_nan from 0 to 1, clear the frame counter and set blink_phase=1; this takes priority over a simultaneous rising edge.
REQ-026 SHALL compute digits_vis = !is_nan | blink_phase.
REQ-027 SHALL discard any upd_valid held high while in HOLD or COMMIT, without side effects.

Reset
REQ-028 SHALL, on reset assertion, immediately set: state IDLE, upd_ready 0, num3..num0 0, op 5, posneg 0, is_nan 0, commit 0, upd_err 0, frame counter 0, blink_phase 1, vblank register 0, holding buffer 0.
REQ-029 SHALL set upd_ready=1 on the first clk edge after reset deasserts.
REQ-030 SHALL discard a pending HOLD update when reset is asserted mid-operation, with no commit pulse.

Structure
REQ-031 SHALL place the shared constants in package vga_disp_pkg: OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_DIV=3, OP_NONE=5, DIGIT_MAX=9, and the state encoding.
REQ-032 SHALL implement the vblank edge detect, frame counter and blink_phase as sub-module frame_blink, with inputs clk, reset, vblank and restart, and output blink_phase.
REQ-033 SHALL keep total RTL within 120-400 lines.

Verification
REQ-034 SHALL cover: with vblank=0, transfer digits 4,3,2,1, op 3, neg 1 -> outputs stay at reset values; raise vblank -> outputs become 4,3,2,1/3/1 two edges after the transfer, commit is 1 cycle wide, upd_ready returns 1 one edge later.
REQ-035 SHALL cover: transfer with upd_num2=12 -> upd_err=1, outputs unchanged, upd_ready stays 1; a following legal transfer -> upd_err=0.
REQ-036 SHALL cover: commit with upd_nan=1 under BLINK_FRAMES=2 -> digits_vis=1; after 2 vblank rises digits_vis=0; after 4 rises digits_vis=1; commit with upd_nan=0 -> digits_vis=1 constantly.
REQ-037 SHALL cover: assert reset while in HOLD -> all outputs at reset values with no commit pulse; upd_ready=1 one edge after reset release.
REQ-038 SHALL cover: hold upd_valid high across HOLD and COMMIT with changing data -> exactly one commit, with the first accepted data.
REQ-039 SHALL cover: transfer with op=4 -> rejected (upd_err=1); transfer with op=5 -> accepted.

Source files
------------

// File: rtl/vga_disp_pkg.sv
// Shared constants, state encoding and update record for the display update controller.
package vga_disp_pkg;

  localparam logic [3:0] OP_ADD    = 4'd0;
  localparam logic [3:0] OP_SUB    = 4'd1;
  localparam logic [3:0] OP_MUL    = 4'd2;
  localparam logic [3:0] OP_DIV    = 4'd3;
  localparam logic [3:0] OP_NONE   = 4'd5;
  localparam logic [3:0] DIGIT_MAX = 4'd9;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HOLD   = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  typedef struct packed {
    logic [3:0] num3;
    logic [3:0] num2;
    logic [3:0] num1;
    logic [3:0] num0;
    logic [3:0] op;
    logic       neg;
    logic       nan;
  } upd_t;

  function automatic logic upd_legal(input upd_t u);
    logic dig_ok, op_ok;
    dig_ok = (u.num3 <= DIGIT_MAX) && (u.num2 <= DIGIT_MAX) &&
             (u.num1 <= DIGIT_MAX) && (u.num0 <= DIGIT_MAX);
    op_ok  = (u.op == OP_ADD) || (u.op == OP_SUB) || (u.op == OP_MUL) ||
             (u.op == OP_DIV) || (u.op == OP_NONE);
    return dig_ok && op_ok;
  endfunction

endpackage

// File: rtl/frame_blink.sv
// Counts vblank rising edges and toggles blink_phase every BLINK_FRAMES rises.
module frame_blink #(
  parameter int BLINK_FRAMES = 30
) (
  input  logic clk,
  input  logic reset,
  input  logic vblank,
  input  logic restart,
  output logic blink_phase
);

  localparam int CW = $clog2(BLINK_FRAMES);

  logic [CW-1:0] cnt;
  logic          vb_q;
  logic          rise;

  assign rise = vblank & ~vb_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vb_q        <= 1'b0;
      cnt         <= '0;
      blink_phase <= 1'b1;
    end else begin
      vb_q <= vblank;
      // A fresh NaN always starts in the visible half, even on a coincident rise.
      if (restart) begin
        cnt         <= '0;
        blink_phase <= 1'b1;
      end else if (rise) begin
        if (cnt == CW'(BLINK_FRAMES - 1)) begin
          cnt         <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/disp_update_ctrl.sv
// Buffers calculator results and commits them to the display registers only during vblank.
module disp_update_ctrl
  import vga_disp_pkg::*;
#(
  parameter int BLINK_FRAMES = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vblank,
  input  logic       upd_valid,
  output logic       upd_ready,
  input  logic [3:0] upd_num3,
  input  logic [3:0] upd_num2,
  input  logic [3:0] upd_num1,
  input  logic [3:0] upd_num0,
  input  logic [3:0] upd_op,
  input  logic       upd_neg,
  input  logic       upd_nan,
  output logic [3:0] num3,
  output logic [3:0] num2,
  output logic [3:0] num1,
  output logic [3:0] num0,
  output logic [3:0] op,
  output logic       posneg,
  output logic       is_nan,
  output logic       digits_vis,
  output logic       commit,
  output logic       upd_err
);

  logic [1:0] state;
  upd_t       upd_in, hold_q;
  logic       xfer, load, restart, blink_phase;

  assign upd_in  = {upd_num3, upd_num2, upd_num1, upd_num0, upd_op, upd_neg, upd_nan};
  assign xfer    = upd_valid & upd_ready;
  assign load    = (state == ST_HOLD) & vblank;
  assign restart = load & hold_q.nan & ~is_nan;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      upd_ready <= 1'b0;
      hold_q    <= '0;
      num3      <= '0;
      num2      <= '0;
      num1      <= '0;
      num0      <= '0;
      op        <= OP_NONE;
      posneg    <= 1'b0;
      is_nan    <= 1'b0;
      commit    <= 1'b0;
      upd_err   <= 1'b0;
    end else begin
      commit <= 1'b0;
      case (state)
        ST_IDLE: begin
          upd_ready <= 1'b1;
          if (xfer) begin
            if (upd_legal(upd_in)) begin
              hold_q    <= upd_in;
              upd_err   <= 1'b0;
              state     <= ST_HOLD;
              upd_ready <= 1'b0;
            end else begin
              upd_err <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (load) begin
            num3   <= hold_q.num3;
            num2   <= hold_q.num2;
            num1   <= hold_q.num1;
            num0   <= hold_q.num0;
            op     <= hold_q.op;
            posneg <= hold_q.neg;
            is_nan <= hold_q.nan;
            commit <= 1'b1;
            state  <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          state     <= ST_IDLE;
          upd_ready <= 1'b1;
        end
        default: begin
          state     <= ST_IDLE;
          upd_ready <= 1'b0;
        end
      endcase
    end
  end

  frame_blink #(.BLINK_FRAMES(BLINK_FRAMES)) u_blink (
    .clk        (clk),
    .reset      (reset),
    .vblank     (vblank),
    .restart    (restart),
    .blink_phase(blink_phase)
  );

  assign digits_vis = ~is_nan | blink_phase;

endmodule

// File: tb/tb_disp_update_ctrl.sv
// Directed bench for disp_update_ctrl with a short blink period.
module tb_disp_update_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       vblank = 1'b0;
  logic       upd_valid = 1'b0;
  logic       upd_ready;
  logic [3:0] upd_num3 = '0, upd_num2 = '0, upd_num1 = '0, upd_num0 = '0, upd_op = '0;
  logic       upd_neg = 1'b0, upd_nan = 1'b0;
  logic [3:0] num3, num2, num1, num0, op;
  logic       posneg, is_nan, digits_vis, commit, upd_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  disp_update_ctrl #(.BLINK_FRAMES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .vblank    (vblank),
    .upd_valid (upd_valid),
    .upd_ready (upd_ready),
    .upd_num3  (upd_num3),
    .upd_num2  (upd_num2),
    .upd_num1  (upd_num1),
    .upd_num0  (upd_num0),
    .upd_op    (upd_op),
    .upd_neg   (upd_neg),
    .upd_nan   (upd_nan),
    .num3      (num3),
    .num2      (num2),
    .num1      (num1),
    .num0      (num0),
    .op        (op),
    .posneg    (posneg),
    .is_nan    (is_nan),
    .digits_vis(digits_vis),
    .commit    (commit),
    .upd_err   (upd_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Display word: num3..num0, op, posneg, is_nan.
  task automatic chk_disp(input string tag, input logic [3:0] n3, n2, n1, n0, o,
                          input logic ng, nn);
    chk(tag, {num3, num2, num1, num0, op, posneg, is_nan}, {n3, n2, n1, n0, o, ng, nn});
  endtask

  task automatic drive(input logic [3:0] n3, n2, n1, n0, o, input logic ng, nn);
    upd_num3 = n3; upd_num2 = n2; upd_num1 = n1; upd_num0 = n0;
    upd_op = o; upd_neg = ng; upd_nan = nn;
  endtask

  // One-cycle offer; the controller is expected to be ready.
  task automatic send(input string tag, input logic [3:0] n3, n2, n1, n0, o,
                      input logic ng, nn);
    drive(n3, n2, n1, n0, o, ng, nn);
    chk({tag, "_ready"}, upd_ready, 1'b1);
    upd_valid = 1'b1;
    tick();
    upd_valid = 1'b0;
  endtask

  task automatic vb_rise();
    vblank = 1'b0;
    tick();
    vblank = 1'b1;
    tick();
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_ready", upd_ready, 1'b0);
    chk_disp("rst_disp", 0, 0, 0, 0, 5, 0, 0);
    chk("rst_commit", commit, 1'b0);
    chk("rst_err", upd_err, 1'b0);
    chk("rst_vis", digits_vis, 1'b1);
    reset = 1'b0;
    tick();
    chk("rel_ready", upd_ready, 1'b1);

    // Transfer outside vblank waits for vblank
    send("t1", 4, 3, 2, 1, 3, 1, 0);
    chk("t1_ready_low", upd_ready, 1'b0);
    tick(); tick();
    chk_disp("t1_held", 0, 0, 0, 0, 5, 0, 0);
    chk("t1_nocommit", commit, 1'b0);
    vblank = 1'b1;
    tick();
    chk_disp("t1_disp", 4, 3, 2, 1, 3, 1, 0);
    chk("t1_commit", commit, 1'b1);
    chk("t1_ready_c", upd_ready, 1'b0);
    tick();
    chk("t1_commit_off", commit, 1'b0);
    chk("t1_ready_back", upd_ready, 1'b1);

    // Transfer during vblank: outputs one edge after transfer edge, ready one more
    send("t2", 9, 8, 7, 6, 1, 0, 0);
    chk_disp("t2_not_yet", 4, 3, 2, 1, 3, 1, 0);
    chk("t2_nocommit", commit, 1'b0);
    tick();
    chk_disp("t2_disp", 9, 8, 7, 6, 1, 0, 0);
    chk("t2_commit", commit, 1'b1);
    tick();
    chk("t2_commit_off", commit, 1'b0);
    chk("t2_ready", upd_ready, 1'b1);

    // Illegal digit
    vblank = 1'b0;
    tick();
    send("bad_dig", 7, 12, 0, 0, 0, 0, 0);
    chk("bad_dig_err", upd_err, 1'b1);
    chk("bad_dig_ready", upd_ready, 1'b1);
    chk_disp("bad_dig_disp", 9, 8, 7, 6, 1, 0, 0);
    send("good", 1, 1, 1, 1, 2, 0, 0);
    chk("good_err_clr", upd_err, 1'b0);
    vblank = 1'b1;
    tick();
    chk_disp("good_disp", 1, 1, 1, 1, 2, 0, 0);
    tick();

    // Operator legality
    send("op4", 2, 2, 2, 2, 4, 0, 0);
    chk("op4_err", upd_err, 1'b1);
    chk("op4_ready", upd_ready, 1'b1);
    send("op5", 3, 3, 3, 3, 5, 0, 0);
    chk("op5_err", upd_err, 1'b0);
    chk("op5_ready", upd_ready, 1'b0);
    tick();
    chk_disp("op5_disp", 3, 3, 3, 3, 5, 0, 0);
    tick();

    // upd_valid held through HOLD and COMMIT
    vblank = 1'b0;
    tick();
    drive(1, 2, 3, 4, 0, 0, 0);
    upd_valid = 1'b1;
    tick();
    drive(9, 9, 9, 9, 1, 1, 0);
    tick();
    chk("hv_hold_nocommit", commit, 1'b0);
    tick();
    vblank = 1'b1;
    tick();
    chk("hv_commit", commit, 1'b1);
    chk_disp("hv_disp", 1, 2, 3, 4, 0, 0, 0);
    drive(8, 8, 8, 8, 2, 0, 0);
    tick();
    chk("hv_commit_once", commit, 1'b0);
    chk("hv_ready", upd_ready, 1'b1);
    upd_valid = 1'b0;
    tick(); tick();
    chk("hv_no_second", commit, 1'b0);
    chk_disp("hv_disp_kept", 1, 2, 3, 4, 0, 0, 0);

    // NaN blink with BLINK_FRAMES=2
    vblank = 1'b0;
    tick();
    send("nan", 0, 0, 0, 0, 5, 0, 1);
    vblank = 1'b1;
    tick();
    chk("nan_commit", commit, 1'b1);
    chk("nan_flag", is_nan, 1'b1);
    chk("nan_vis0", digits_vis, 1'b1);
    tick();
    vb_rise();
    chk("nan_vis1", digits_vis, 1'b1);
    vb_rise();
    chk("nan_vis2", digits_vis, 1'b0);
    vb_rise();
    chk("nan_vis3", digits_vis, 1'b0);
    vb_rise();
    chk("nan_vis4", digits_vis, 1'b1);
    send("num", 5, 5, 5, 5, 0, 0, 0);
    tick();
    chk("num_flag", is_nan, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      vb_rise();
      chk($sformatf("num_vis%0d", i), digits_vis, 1'b1);
    end

    // Reset while holding an update
    vblank = 1'b0;
    tick();
    send("rh", 6, 6, 6, 6, 1, 1, 0);
    reset = 1'b1;
    #1;
    chk_disp("rh_disp", 0, 0, 0, 0, 5, 0, 0);
    chk("rh_ready", upd_ready, 1'b0);
    chk("rh_err", upd_err, 1'b0);
    vblank = 1'b1;
    tick();
    chk("rh_nocommit", commit, 1'b0);
    reset = 1'b0;
    tick();
    chk("rh_rel_ready", upd_ready, 1'b1);
    chk("rh_rel_nocommit", commit, 1'b0);
    tick();
    chk("rh_rel_nocommit2", commit, 1'b0);
    chk_disp("rh_rel_disp", 0, 0, 0, 0, 5, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
